alu_arbiter: RTL
================

# alu_arbiter

Round-robin arbiter sharing one RV32I integer ALU between two requesters: requester 0 is the execute stage, requester 1 is the address/branch-compare path. Each requester presents operands and a 4-bit operation on a valid/ready channel. The block grants one request per cycle, drives the shared ALU combinationally, and captures the result in a one-entry response register tagged with the requester ID. The register is held until downstream accepts it.

## Interface
- XLEN, 32, operand/result width
- SEL_W, 4, operation-select width
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset; one clock; reset is synchronous and active-low
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle (grant)
- req0_a, req0_b / req1_a, req1_b  in  XLEN  operands
- req0_sel / req1_sel  in  SEL_W  operation: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND
- rsp_valid  out  1  response register full
- rsp_ready  in  1  downstream accepts response
- rsp_id  out  1  requester that issued the response
- rsp_data  out  XLEN  ALU result
- rsp_err  out  1  illegal select (10–15) was issued

## Operation
- States: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
- can_accept = EMPTY | (FULL & rsp_ready).
- Grant:
  - Only one requester valid and can_accept: that requester gets ready=1.
  - Both valid: grant the requester not in last_grant.
  - At most one ready high per cycle; ready is never high when can_accept=0.
- On grant:
  - Mux the granted a/b/sel into the ALU.
  - For sel 2/6/7, b is masked to b[4:0] before the ALU (RV32I shift amount).
  - rsp_data ← ALU output; rsp_id ← granted index; rsp_err ← 0.
  - last_grant ← granted index; state → FULL.
- Illegal sel 10–15: the request is still granted and consumed. rsp_data ← 0, rsp_err ← 1.
- FULL & rsp_ready with no grant: → EMPTY.
- FULL & rsp_ready with a grant: stays FULL with the new contents (back-to-back, full throughput).
- FULL & !rsp_ready:
  - rsp_id, rsp_data and rsp_err hold stable.
  - Both req_ready are 0.
- Requesters must hold a/b/sel stable while valid and not ready. The arbiter does not re-sample a request after granting it.
- Fairness: a continuously valid requester is granted within 2 accepting cycles.

## Timing
- Reset (rst_n=0 at a clk edge):
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0.
  - last_grant=1, so requester 0 wins the first contended cycle.
  - req_ready=0 while rst_n=0.
- Reset mid-operation discards any held response. No response is produced for a request granted in the reset cycle.
- Latency: a request granted at edge N has rsp_valid=1 after edge N; rsp_data is visible in cycle N+1.
- req_ready is combinational from req_valid, state, rsp_ready and last_grant. rsp_* are registered only.
- The ALU path is purely combinational within the grant cycle. The single-cycle ALU is the critical path.

## Structure
- Shared package rv32i_pkg holds:
  - XLEN and SEL_W.
  - ALU opcode constants ALU_ADD … ALU_AND (0–9).
  - ALU_SEL_MAX = 9, used for the illegal-select check.
- Sub-module: one instance of the existing ALU module (ports Register1_value, Register2_value, ALU_sel, ALU_output), used unmodified.
- Arbiter, mask, state and response register live in alu_arbiter.

## Test plan
- Reset then single request: req0 ADD a=5, b=7 → req0_ready=1 that cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=12, rsp_err=0.
- Contention: both valid continuously, rsp_ready=1; req0 SUB 10−3, req1 XOR 0xF0^0x0F → grants alternate 0,1,0,1 starting with 0; responses 7 (id 0), 0xFF (id 1), one per cycle.
- Backpressure: rsp_ready=0 for 3 cycles after a req1 SLTU 1<2 → rsp_data=1, rsp_id=1 stable for 3 cycles, both ready=0; on rsp_ready=1 the pending req0 is granted the same cycle.
- Shift mask: req0 SLL a=1, b=0x0000_0024 → rsp_data=0x10 (shift by 4, not 36).
- Illegal op: req1 sel=12 → granted, rsp_data=0, rsp_err=1, then normal operation resumes.
- Reset mid-FULL: rsp_valid=1, rsp_ready=0, rst_n pulsed low for one cycle → rsp_valid=0, rsp_data=0; next contended grant goes to requester 0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I ALU definitions: widths, opcode encodings and the response record.
package rv32i_pkg;
   localparam int XLEN  = 32;
   localparam int SEL_W = 4;

   localparam logic [SEL_W-1:0] ALU_ADD  = 4'd0;
   localparam logic [SEL_W-1:0] ALU_SUB  = 4'd1;
   localparam logic [SEL_W-1:0] ALU_SLL  = 4'd2;
   localparam logic [SEL_W-1:0] ALU_SLT  = 4'd3;
   localparam logic [SEL_W-1:0] ALU_SLTU = 4'd4;
   localparam logic [SEL_W-1:0] ALU_XOR  = 4'd5;
   localparam logic [SEL_W-1:0] ALU_SRL  = 4'd6;
   localparam logic [SEL_W-1:0] ALU_SRA  = 4'd7;
   localparam logic [SEL_W-1:0] ALU_OR   = 4'd8;
   localparam logic [SEL_W-1:0] ALU_AND  = 4'd9;
   localparam logic [SEL_W-1:0] ALU_SEL_MAX = 4'd9;

   typedef struct packed {
      logic            id;
      logic            err;
      logic [XLEN-1:0] data;
   } alu_rsp_t;

   function automatic logic is_shift_op(input logic [SEL_W-1:0] sel);
      return (sel == ALU_SLL) || (sel == ALU_SRL) || (sel == ALU_SRA);
   endfunction
endpackage

// File: rtl/alu.sv
// Single-cycle RV32I integer ALU; shifts use the full second operand as given.
module alu
   import rv32i_pkg::*;
(
   input  logic [XLEN-1:0]  Register1_value,
   input  logic [XLEN-1:0]  Register2_value,
   input  logic [SEL_W-1:0] ALU_sel,
   output logic [XLEN-1:0]  ALU_output
);
   always_comb begin
      ALU_output = '0;
      case (ALU_sel)
         ALU_ADD:  ALU_output = Register1_value + Register2_value;
         ALU_SUB:  ALU_output = Register1_value - Register2_value;
         ALU_SLL:  ALU_output = Register1_value << Register2_value;
         ALU_SLT:  ALU_output = {{(XLEN-1){1'b0}}, $signed(Register1_value) < $signed(Register2_value)};
         ALU_SLTU: ALU_output = {{(XLEN-1){1'b0}}, Register1_value < Register2_value};
         ALU_XOR:  ALU_output = Register1_value ^ Register2_value;
         ALU_SRL:  ALU_output = Register1_value >> Register2_value;
         ALU_SRA:  ALU_output = $unsigned($signed(Register1_value) >>> Register2_value);
         ALU_OR:   ALU_output = Register1_value | Register2_value;
         ALU_AND:  ALU_output = Register1_value & Register2_value;
         default:  ALU_output = '0;
      endcase
   end
endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared ALU, with a single-entry
// response register that is held until downstream takes it.
module alu_arbiter
   import rv32i_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [XLEN-1:0]  req0_a,
   input  logic [XLEN-1:0]  req0_b,
   input  logic [SEL_W-1:0] req0_sel,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [XLEN-1:0]  req1_a,
   input  logic [XLEN-1:0]  req1_b,
   input  logic [SEL_W-1:0] req1_sel,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [XLEN-1:0]  rsp_data,
   output logic             rsp_err
);
   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   logic [0:0]       state;
   logic             last_grant;
   alu_rsp_t         rsp_q;
   logic             can_accept, gnt0, gnt1, gnt_any, gnt_id, illegal;
   logic [XLEN-1:0]  op_a, op_b, op_b_m, alu_out;
   logic [SEL_W-1:0] op_sel;

   // Reset gates the grant so nothing is consumed while the block is held in reset.
   assign can_accept = rst_n & ((state == ST_EMPTY) | rsp_ready);
   assign gnt0       = can_accept & req0_valid & (~req1_valid | last_grant);
   assign gnt1       = can_accept & req1_valid & (~req0_valid | ~last_grant);
   assign gnt_any    = gnt0 | gnt1;
   assign gnt_id     = gnt1;
   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   assign op_a    = gnt_id ? req1_a   : req0_a;
   assign op_b    = gnt_id ? req1_b   : req0_b;
   assign op_sel  = gnt_id ? req1_sel : req0_sel;
   assign op_b_m  = is_shift_op(op_sel) ? {{(XLEN-5){1'b0}}, op_b[4:0]} : op_b;
   assign illegal = op_sel > ALU_SEL_MAX;

   alu u_alu (
      .Register1_value (op_a),
      .Register2_value (op_b_m),
      .ALU_sel         (op_sel),
      .ALU_output      (alu_out)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_EMPTY;
         last_grant <= 1'b1;
         rsp_q      <= '0;
      end else if (gnt_any) begin
         state      <= ST_FULL;
         last_grant <= gnt_id;
         rsp_q.id   <= gnt_id;
         rsp_q.err  <= illegal;
         rsp_q.data <= illegal ? '0 : alu_out;
      end else if (rsp_ready) begin
         state <= ST_EMPTY;
      end
   end

   assign rsp_valid = (state == ST_FULL);
   assign rsp_id    = rsp_q.id;
   assign rsp_data  = rsp_q.data;
   assign rsp_err   = rsp_q.err;
endmodule
